// File: rtl/carry_sum_stage.sv
// carry_sum_stage: holds propagate/carry-in per operation in an in-order FIFO and
// combines each entry with the carry-tree output into a registered sum, carry-out and overflow.
module carry_sum_stage #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pg_valid,
    input  logic [N-1:0]             p_in,
    input  logic                     cin_in,
    input  logic                     c_valid,
    input  logic [N-1:0]             c_in,
    output logic [N-1:0]             sum_out,
    output logic                     cout,
    output logic                     ovf,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     err_underflow,
    output logic                     err_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, ovf_q, valid_q, err_unf_q, err_ovf_q;
    logic          empty, full, bypass, pop, push, combine;
    logic [N:0]    head;

    // An empty FIFO with both valids means a combinational tree: skip storage entirely.
    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == CW'(DEPTH);
        bypass   = empty & pg_valid & c_valid;
        pop      = c_valid & ~empty;
        push     = pg_valid & ~bypass & (~full | pop);
        combine  = bypass | pop;
        head     = bypass ? {p_in, cin_in} : mem_q[rd_ptr_q];
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        sum_d    = head[N:1] ^ {c_in[N-2:0], head[0]};
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {p_in, cin_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_unf_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= combine;
            err_unf_q <= err_unf_q | (c_valid & empty & ~pg_valid);
            err_ovf_q <= err_ovf_q | (pg_valid & full & ~c_valid);
            if (combine) begin
                sum_q  <= sum_d;
                cout_q <= c_in[N-1];
                ovf_q  <= c_in[N-1] ^ c_in[N-2];
            end
        end
    end

    assign sum_out       = sum_q;
    assign cout          = cout_q;
    assign ovf           = ovf_q;
    assign out_valid     = valid_q;
    assign fifo_cnt      = cnt_q;
    assign err_underflow = err_unf_q;
    assign err_overflow  = err_ovf_q;
endmodule

// File: tb/tb_carry_sum_stage.sv
// tb_carry_sum_stage: directed checks of bypass, streaming, fill/overflow, underflow and reset.
module tb_carry_sum_stage;
    logic        clk, rst, pg_valid, cin_in, c_valid;
    logic [31:0] p_in, c_in, sum_out;
    logic        cout, ovf, out_valid, err_underflow, err_overflow;
    logic [2:0]  fifo_cnt;
    int          checks = 0;
    int          fails = 0;

    carry_sum_stage #(.N(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pg_valid(pg_valid), .p_in(p_in), .cin_in(cin_in),
        .c_valid(c_valid), .c_in(c_in), .sum_out(sum_out), .cout(cout), .ovf(ovf),
        .out_valid(out_valid), .fifo_cnt(fifo_cnt), .err_underflow(err_underflow),
        .err_overflow(err_overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pg_valid = 0; c_valid = 0; p_in = '0; cin_in = 0; c_in = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic push_entry(input logic [31:0] p, input logic ci);
        pg_valid = 1; p_in = p; cin_in = ci; c_valid = 0;
        tick();
        pg_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({sum_out, cout, ovf, out_valid} !== 35'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {sum_out, cout, ovf, out_valid}); end
        checks++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
        checks++; if ({err_underflow, err_overflow} !== 2'b00) begin fails++; $display("FAIL reset_errs: got %b want 00", {err_underflow, err_overflow}); end
    endtask

    task automatic test_bypass();
        pg_valid = 1; p_in = 32'hFFFF_FFFE; cin_in = 0; c_valid = 1; c_in = 32'hFFFF_FFFF;
        tick();
        idle();
        checks++; if (sum_out !== 32'h0) begin fails++; $display("FAIL bypass_sum: got %h want 00000000", sum_out); end
        checks++; if ({cout, ovf, out_valid} !== 3'b101) begin fails++; $display("FAIL bypass_flags: got %b want 101", {cout, ovf, out_valid}); end
        checks++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL bypass_cnt: got %0d want 0", fifo_cnt); end
        checks++; if ({err_underflow, err_overflow} !== 2'b00) begin fails++; $display("FAIL bypass_errs: got %b want 00", {err_underflow, err_overflow}); end
        tick();
        checks++; if (out_valid !== 1'b0 || sum_out !== 32'h0 || cout !== 1'b1) begin fails++; $display("FAIL bypass_hold: got v=%b s=%h c=%b want v=0 s=00000000 c=1", out_valid, sum_out, cout); end
    endtask

    task automatic test_back_to_back();
        pg_valid = 1; p_in = 32'h7FFF_FFFE; cin_in = 0;
        tick();
        checks++; if (fifo_cnt !== 3'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL b2b_first_push: got cnt=%0d v=%b want cnt=1 v=0", fifo_cnt, out_valid); end
        p_in = 32'h0000_0006; cin_in = 1; c_valid = 1; c_in = 32'h7FFF_FFFF;
        tick();
        checks++; if (sum_out !== 32'h8000_0000) begin fails++; $display("FAIL b2b_sum_a: got %h want 80000000", sum_out); end
        checks++; if ({cout, ovf, out_valid} !== 3'b011) begin fails++; $display("FAIL b2b_flags_a: got %b want 011", {cout, ovf, out_valid}); end
        checks++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL b2b_cnt_stream: got %0d want 1", fifo_cnt); end
        pg_valid = 0; c_in = 32'h0000_0007;
        tick();
        checks++; if (sum_out !== 32'h0000_0009) begin fails++; $display("FAIL b2b_sum_b: got %h want 00000009", sum_out); end
        checks++; if ({cout, ovf, out_valid} !== 3'b001) begin fails++; $display("FAIL b2b_flags_b: got %b want 001", {cout, ovf, out_valid}); end
        checks++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL b2b_cnt_end: got %0d want 0", fifo_cnt); end
        idle();
        tick();
        checks++; if (out_valid !== 1'b0 || sum_out !== 32'h9) begin fails++; $display("FAIL b2b_idle: got v=%b s=%h want v=0 s=00000009", out_valid, sum_out); end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] exp [4];
        exp[0] = 32'h1111_1110; exp[1] = 32'h2222_2222; exp[2] = 32'h3333_3332; exp[3] = 32'h4444_4444;
        for (int k = 1; k <= 4; k++) push_entry(32'h1111_1111 * k, k[0]);
        checks++; if (fifo_cnt !== 3'd4 || err_overflow !== 1'b0) begin fails++; $display("FAIL fill_cnt: got cnt=%0d eo=%b want cnt=4 eo=0", fifo_cnt, err_overflow); end
        push_entry(32'h5555_5555, 1);
        checks++; if (fifo_cnt !== 3'd4 || err_overflow !== 1'b1) begin fails++; $display("FAIL overflow_flag: got cnt=%0d eo=%b want cnt=4 eo=1", fifo_cnt, err_overflow); end
        c_valid = 1; c_in = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || sum_out !== exp[k]) begin fails++; $display("FAIL drain_%0d: got v=%b s=%h want v=1 s=%h", k, out_valid, sum_out, exp[k]); end
        end
        c_valid = 0;
        checks++; if (fifo_cnt !== 3'd0 || err_overflow !== 1'b1) begin fails++; $display("FAIL drain_end: got cnt=%0d eo=%b want cnt=0 eo=1", fifo_cnt, err_overflow); end
    endtask

    task automatic test_underflow();
        c_valid = 1; c_in = 32'hFFFF_FFFF; pg_valid = 0;
        tick();
        idle();
        checks++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL underflow_flag: got %b want 1", err_underflow); end
        checks++; if (out_valid !== 1'b0 || sum_out !== 32'h4444_4444 || cout !== 1'b0) begin fails++; $display("FAIL underflow_hold: got v=%b s=%h c=%b want v=0 s=44444444 c=0", out_valid, sum_out, cout); end
        checks++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL underflow_cnt: got %0d want 0", fifo_cnt); end
        repeat (3) tick();
        checks++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL underflow_sticky: got %b want 1", err_underflow); end
        do_reset();
        checks++; if ({err_underflow, err_overflow} !== 2'b00) begin fails++; $display("FAIL err_clear: got %b want 00", {err_underflow, err_overflow}); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [4];
        exp[0] = 32'h2222_2222; exp[1] = 32'h3333_3332; exp[2] = 32'h4444_4444; exp[3] = 32'h5555_5555;
        for (int k = 1; k <= 4; k++) push_entry(32'h1111_1111 * k, k[0]);
        pg_valid = 1; p_in = 32'h5555_5555; cin_in = 0; c_valid = 1; c_in = '0;
        tick();
        pg_valid = 0;
        checks++; if (out_valid !== 1'b1 || sum_out !== 32'h1111_1110) begin fails++; $display("FAIL full_pp_out: got v=%b s=%h want v=1 s=11111110", out_valid, sum_out); end
        checks++; if (fifo_cnt !== 3'd4 || err_overflow !== 1'b0) begin fails++; $display("FAIL full_pp_cnt: got cnt=%0d eo=%b want cnt=4 eo=0", fifo_cnt, err_overflow); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || sum_out !== exp[k]) begin fails++; $display("FAIL full_pp_drain_%0d: got v=%b s=%h want v=1 s=%h", k, out_valid, sum_out, exp[k]); end
        end
        idle();
        checks++; if (fifo_cnt !== 3'd0 || err_underflow !== 1'b0) begin fails++; $display("FAIL full_pp_end: got cnt=%0d eu=%b want cnt=0 eu=0", fifo_cnt, err_underflow); end
    endtask

    task automatic test_reset_midstream();
        push_entry(32'hAAAA_AAAA, 0);
        push_entry(32'h0F0F_0F0F, 1);
        checks++; if (fifo_cnt !== 3'd2) begin fails++; $display("FAIL mid_pending: got %0d want 2", fifo_cnt); end
        do_reset();
        checks++; if ({sum_out, cout, ovf, out_valid} !== 35'd0 || fifo_cnt !== 3'd0) begin fails++; $display("FAIL mid_reset: got %h cnt=%0d want 0 cnt=0", {sum_out, cout, ovf, out_valid}, fifo_cnt); end
        c_valid = 1; c_in = 32'hFFFF_FFFF;
        tick();
        idle();
        checks++; if (err_underflow !== 1'b1 || out_valid !== 1'b0 || sum_out !== 32'h0) begin fails++; $display("FAIL mid_stale: got eu=%b v=%b s=%h want eu=1 v=0 s=00000000", err_underflow, out_valid, sum_out); end
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_bypass();
        test_back_to_back();
        test_fill_overflow();
        test_underflow();
        test_full_push_pop();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/carry_sum_stage.md
Name: carry_sum_stage

Overview:
- Downstream consumer of the parallel-prefix carry tree in the adder datapath.
- Holds each operation's propagate vector and carry-in in a small in-order FIFO while the tree resolves carries.
- Pairs the held entry with the tree's carry vector when it arrives, then produces a registered sum, carry-out and signed overflow.
- Works unchanged whether the tree is combinational (0 cycles) or pipelined (1+ cycles).

Parameters:
N, 32, operand width in bits; must match the carry tree's N.
DEPTH, 4, entries in the propagate/carry-in holding FIFO; a power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
pg_valid  input  1  p_in/cin_in valid; asserted in the same cycle g/p are presented to the carry tree.
p_in  input  N  per-bit propagate (a ^ b).
cin_in  input  1  adder carry-in. It is already folded into g[0] upstream, so tree carries include it.
c_valid  input  1  carry tree out_valid.
c_in  input  N  carry tree output; c_in[j] = carry out of bit j.
sum_out  output  N  registered sum.
cout  output  1  registered carry-out, c_in[N-1].
ovf  output  1  registered signed overflow, c_in[N-1] ^ c_in[N-2].
out_valid  output  1  one-cycle pulse per completed sum.
fifo_cnt  output  $clog2(DEPTH)+1  current occupancy.
err_underflow  output  1  sticky; set when c_valid arrives with no pending entry.
err_overflow  output  1  sticky; set when a push is attempted while full.

Behaviour:
- Reset (rst=1 at a clock edge):
  - sum_out, cout, ovf, out_valid = 0.
  - FIFO pointers and fifo_cnt = 0.
  - err_underflow, err_overflow = 0.
  - Entries in flight are discarded; nothing is output for them after reset.
- Push: pg_valid=1 writes {p_in, cin_in} at the write pointer, unless full and no simultaneous pop.
- Pop: c_valid=1 consumes the oldest entry, in order.
- Combine, using the popped entry {p, ci}:
  - sum[0] = p[0] ^ ci
  - sum[j] = p[j] ^ c_in[j-1] for j = 1..N-1
  - cout = c_in[N-1]
  - ovf = c_in[N-1] ^ c_in[N-2]
  - All results are registered. Latency is exactly 1 cycle from c_valid to out_valid.
- Bypass: if the FIFO is empty and pg_valid and c_valid are both high in the same cycle (combinational tree), the combine uses p_in/cin_in directly.
  - fifo_cnt is unchanged and no error is raised.
- Non-empty with push and pop in the same cycle: the pop takes the head, the push is written at the tail, fifo_cnt is unchanged.
- Full with push and pop in the same cycle: both are accepted; no overflow error.
- Full, push without pop: the push is dropped and err_overflow is set. FIFO contents are unchanged.
- Empty, c_valid=1, pg_valid=0: err_underflow is set, out_valid stays 0, and sum_out/cout/ovf keep their old values.
- Pointers wrap modulo DEPTH. fifo_cnt ranges 0..DEPTH.
- Hold behaviour:
  - sum_out, cout and ovf hold their last value when out_valid=0.
  - out_valid is high only in the cycle after a successful combine.
- Error flags: once set, they clear only on rst.
- No backpressure: the downstream consumer always accepts out_valid.

Test Plan:
- Combinational tree, N=32, bypass: a=0xFFFFFFFF, b=0x00000001, cin=0 (p=0xFFFFFFFE, c=0xFFFFFFFF) with pg_valid and c_valid high together -> next cycle sum_out=0x00000000, cout=1, ovf=0, out_valid=1, fifo_cnt=0.
- Pipelined tree (1-cycle delay), back-to-back operations:
  - 0x7FFFFFFF+1 -> sum 0x80000000, ovf=1, cout=0.
  - 5+3 with cin=1 -> sum 0x00000009, cout=0.
  - Results appear on consecutive cycles, in order, each 1 cycle after its c_valid; fifo_cnt stays at 1 during streaming.
- Fill and overflow: DEPTH=4; 5 pg_valid pulses with c_valid held low -> fifo_cnt=4 and err_overflow=1 after the 5th push. Then 4 c_valid pulses -> the 4 original entries come out in order and fifo_cnt returns to 0.
- Underflow: c_valid=1 with the FIFO empty and pg_valid=0 -> err_underflow=1, no out_valid, sum_out unchanged. The flag stays set until rst.
- Full with simultaneous push and pop: with 4 entries held, assert pg_valid and c_valid together -> head entry is output, the new entry is appended, fifo_cnt=4, err_overflow stays 0.
- Reset mid-stream: rst asserted with 2 entries pending -> next cycle all outputs are 0 and fifo_cnt=0. A stale c_valid afterwards raises err_underflow and produces no out_valid.
